// File: rtl/cpu_sequencer_if.sv
// Control-side bundle between the sequencer, board inputs, control unit and datapath enables.
// Sequencer drives the enables and status; everything else is sampled on clk.
interface cpu_sequencer_if #(
  parameter int PC_WIDTH  = 8,
  parameter int CNT_WIDTH = 8
);
  logic                 run;
  logic                 step;
  logic                 bp_en;
  logic [PC_WIDTH-1:0]  bp_addr;
  logic [PC_WIDTH-1:0]  pc;
  logic                 reg_write;
  logic                 cont;
  logic                 ir_en;
  logic                 pc_en;
  logic                 rf_we;
  logic [2:0]           state;
  logic                 halted;
  logic                 bp_hit;
  logic [CNT_WIDTH-1:0] instr_count;

  modport slave (
    input  run, step, bp_en, bp_addr, pc, reg_write, cont,
    output ir_en, pc_en, rf_we, state, halted, bp_hit, instr_count
  );

  modport master (
    output run, step, bp_en, bp_addr, pc, reg_write, cont,
    input  ir_en, pc_en, rf_we, state, halted, bp_hit, instr_count
  );
endinterface

// File: rtl/cpu_sequencer.sv
// Five-cycle FSM gating IR load, PC update and register write; free-run, single-step, breakpoint.
// One instruction per 5 clocks; step edges outside IDLE are dropped, HALT is left only by reset.
module cpu_sequencer #(
  parameter int PC_WIDTH  = 8,
  parameter int CNT_WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  cpu_sequencer_if.slave    bus
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FETCH     = 3'd1,
    DECODE    = 3'd2,
    EXEC      = 3'd3,
    WRITEBACK = 3'd4,
    HALT      = 3'd5
  } state_t;

  state_t               st;
  state_t               nxt;
  logic                 step_q;
  logic                 step_edge;
  logic                 stop;
  logic [PC_WIDTH-1:0]  pc_cur;
  logic [PC_WIDTH-1:0]  bp_cur;
  logic [CNT_WIDTH-1:0] cnt;
  logic                 ir_en_r;
  logic                 pc_en_r;
  logic                 halted_r;

  assign pc_cur    = bus.pc;
  assign bp_cur    = bus.bp_addr;
  assign stop      = bus.bp_en & (pc_cur == bp_cur);
  assign step_edge = bus.step & ~step_q;

  // A step edge starts an instruction even at the breakpoint, which is how a stop is released.
  always_comb begin
    nxt = st;
    case (st)
      IDLE:      if (step_edge || (bus.run && !stop)) nxt = FETCH;
      FETCH:     nxt = DECODE;
      DECODE:    nxt = bus.cont ? EXEC : HALT;
      EXEC:      nxt = WRITEBACK;
      WRITEBACK: nxt = IDLE;
      HALT:      nxt = HALT;
      default:   nxt = IDLE;
    endcase
  end

  // Enables are registered off the next state so they line up exactly with the state they decode.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st       <= IDLE;
      step_q   <= 1'b1;
      cnt      <= '0;
      ir_en_r  <= 1'b0;
      pc_en_r  <= 1'b0;
      halted_r <= 1'b0;
    end else begin
      st       <= nxt;
      step_q   <= bus.step;
      ir_en_r  <= (nxt == FETCH);
      pc_en_r  <= (nxt == WRITEBACK);
      halted_r <= (nxt == HALT);
      if (st == WRITEBACK) cnt <= cnt + 1'b1;
    end
  end

  assign bus.state       = st;
  assign bus.ir_en       = ir_en_r;
  assign bus.pc_en       = pc_en_r;
  assign bus.rf_we       = pc_en_r & bus.reg_write;
  assign bus.halted      = halted_r;
  assign bus.bp_hit      = (st == IDLE) & bus.run & stop;
  assign bus.instr_count = cnt;

endmodule
